// File: rtl/matrix_pkg.sv
// Shared types for the matrix calculator control path.
// Opcodes, sequencer states and display step prompts.
package matrix_pkg;

  localparam int unsigned REG_COUNT = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_TRN = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_A   = 3'd1,
    GET_B   = 3'd2,
    GET_DST = 3'd3,
    EXEC    = 3'd4,
    WRITE   = 3'd5
  } seq_state_t;

  localparam logic [1:0] STEP_NONE = 2'd0;
  localparam logic [1:0] STEP_A    = 2'd1;
  localparam logic [1:0] STEP_B    = 2'd2;
  localparam logic [1:0] STEP_DST  = 2'd3;

endpackage

// File: rtl/seq_timeout_counter.sv
// Cycle counter that flags when a runtime limit is reached.
// Saturates at the terminal count until cleared.
module seq_timeout_counter #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  // Expires on the limit-th cycle counted from a clear.
  assign expired_o = (cnt_q == limit_i - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (!expired_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Operation sequencer: collects operand/destination selections,
// launches the matrix ALU and strobes the register-file write.
module matrix_op_sequencer
  import matrix_pkg::*;
#(
  parameter int unsigned SEL_TIMEOUT  = 1_000_000,
  parameter int unsigned EXEC_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [1:0] op_code,
  input  logic       reg_valid,
  input  logic [2:0] reg_sel,
  input  logic       cancel,
  input  logic       alu_done,
  output logic       alu_start,
  output logic [1:0] alu_op,
  output logic [1:0] rd_addr_a,
  output logic [1:0] rd_addr_b,
  output logic [1:0] wr_addr,
  output logic       wr_en,
  output logic       busy,
  output logic [1:0] step,
  output logic       err
);

  localparam logic [CNT_W-1:0] SEL_LIM  = CNT_W'(SEL_TIMEOUT);
  localparam logic [CNT_W-1:0] EXEC_LIM = CNT_W'(EXEC_TIMEOUT);

  seq_state_t state_q, state_d;
  op_t        op_q, op_d;
  logic [1:0] a_q, a_d, b_q, b_d, dst_q, dst_d;
  logic [1:0] step_q, step_d;
  logic       start_q, start_d;
  logic       wren_q, wren_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic             sel_ok;
  logic [1:0]       sel_idx;
  logic             cnt_clr;
  logic             expired;
  logic [CNT_W-1:0] limit;

  assign sel_ok  = reg_valid && (reg_sel != 3'd0) &&
                   (reg_sel <= 3'(REG_COUNT));
  assign sel_idx = 2'(reg_sel - 3'd1);
  assign limit   = (state_q == EXEC) ? EXEC_LIM : SEL_LIM;

  seq_timeout_counter #(
    .CNT_W(CNT_W)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .limit_i  (limit),
    .expired_o(expired)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    start_d = 1'b0;
    wren_d  = 1'b0;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          state_d = GET_A;
          op_d    = op_t'(op_code);
        end
      end
      GET_A: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (sel_ok) begin
          a_d     = sel_idx;
          cnt_clr = 1'b1;
          if (op_q == OP_TRN) begin
            b_d     = 2'd0;
            state_d = GET_DST;
          end else begin
            state_d = GET_B;
          end
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GET_B: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (sel_ok) begin
          b_d     = sel_idx;
          cnt_clr = 1'b1;
          state_d = GET_DST;
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GET_DST: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (sel_ok) begin
          dst_d   = sel_idx;
          cnt_clr = 1'b1;
          start_d = 1'b1;
          state_d = EXEC;
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      EXEC: begin
        // start_q marks the launch cycle; a done there is stale.
        if (cancel) begin
          state_d = IDLE;
        end else if (alu_done && !start_q) begin
          wren_d  = 1'b1;
          state_d = WRITE;
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q || state_q == IDLE) begin
      cnt_clr = 1'b1;
    end
    busy_d = (state_d != IDLE);
    unique case (state_d)
      GET_A:   step_d = STEP_A;
      GET_B:   step_d = STEP_B;
      GET_DST: step_d = STEP_DST;
      default: step_d = STEP_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      step_q  <= STEP_NONE;
      start_q <= 1'b0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
      step_q  <= step_d;
      start_q <= start_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign alu_start = start_q;
  assign alu_op    = op_q;
  assign rd_addr_a = a_q;
  assign rd_addr_b = b_q;
  assign wr_addr   = dst_q;
  assign wr_en     = wren_q;
  assign busy      = busy_q;
  assign step      = step_q;
  assign err       = err_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Scoreboard bench: expected writes/errors are queued by stimulus,
// a negedge monitor pops them whenever wr_en or err is seen.
module tb_matrix_op_sequencer;

  typedef struct {
    bit         is_err;
    logic [1:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic [1:0] op_code = 2'd0;
  logic       reg_valid = 1'b0;
  logic [2:0] reg_sel = 3'd0;
  logic       cancel = 1'b0;
  logic       alu_done = 1'b0;
  logic       alu_start;
  logic [1:0] alu_op, rd_addr_a, rd_addr_b, wr_addr, step;
  logic       wr_en, busy, err;

  int   tests = 0;
  int   fails = 0;
  int   starts = 0;
  exp_t sb[$];

  matrix_op_sequencer #(
    .SEL_TIMEOUT (16),
    .EXEC_TIMEOUT(8),
    .CNT_W       (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .reg_valid(reg_valid),
    .reg_sel  (reg_sel),
    .cancel   (cancel),
    .alu_done (alu_done),
    .alu_start(alu_start),
    .alu_op   (alu_op),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .wr_addr  (wr_addr),
    .wr_en    (wr_en),
    .busy     (busy),
    .step     (step),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per wr_en/err cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && alu_start) starts++;
      if (!rst && (wr_en || err)) begin
        if (sb.size() == 0) begin
          chk("unexpected_evt", {30'd0, wr_en, err}, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.is_err) begin
            chk("err_evt", {30'd0, wr_en, err}, 32'd1);
          end else begin
            chk("wr_evt", {wr_en, err, alu_op, rd_addr_a,
                           rd_addr_b, wr_addr},
                {1'b1, 1'b0, e.op, e.a, e.b, e.d});
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int c);
    op_valid = 1'b1;
    op_code  = 2'(c);
    cyc();
    op_valid = 1'b0;
  endtask

  task automatic sel(input int v);
    reg_valid = 1'b1;
    reg_sel   = 3'(v);
    cyc();
    reg_valid = 1'b0;
  endtask

  task automatic done();
    alu_done = 1'b1;
    cyc();
    alu_done = 1'b0;
  endtask

  function automatic exp_t wr(input int o, a, b, d);
    exp_t e;
    e.is_err = 1'b0;
    e.op = 2'(o);
    e.a  = 2'(a);
    e.b  = 2'(b);
    e.d  = 2'(d);
    return e;
  endfunction

  function automatic exp_t er();
    exp_t e;
    e = wr(0, 0, 0, 0);
    e.is_err = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] outs();
    return {16'd0, alu_start, alu_op, rd_addr_a, rd_addr_b,
            wr_addr, wr_en, busy, step, err};
  endfunction

  initial begin
    int s0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("reset_outs", outs(), 32'd0);

    // ADD: A=2, B=3, DST=1
    sb.push_back(wr(0, 1, 2, 0));
    op(0);
    chk("add_busy_step", {busy, step}, {1'b1, 2'd1});
    sel(2);
    chk("add_step_b", step, 2);
    sel(3);
    chk("add_step_d", step, 3);
    sel(1);
    chk("add_start", {alu_start, busy, step}, {1'b1, 1'b1, 2'd0});
    cyc();
    chk("add_start_1cyc", alu_start, 0);
    repeat (4) cyc();
    done();
    chk("add_wr_en", wr_en, 1);
    cyc();
    chk("add_idle", {busy, wr_en}, 0);

    // TRN: A=4, DST=2, B skipped; done on start cycle ignored
    sb.push_back(wr(3, 3, 0, 1));
    op(3);
    sel(4);
    chk("trn_skip_b", step, 3);
    sel(2);
    chk("trn_start", alu_start, 1);
    done();
    chk("trn_done_ign", {busy, wr_en}, {1'b1, 1'b0});
    cyc();
    done();
    chk("trn_wr_en", wr_en, 1);
    cyc();
    chk("trn_idle", busy, 0);

    // Invalid selections and op while busy, then A=B=DST=1
    sb.push_back(wr(1, 0, 0, 0));
    op(1);
    sel(0);
    sel(6);
    op(2);
    chk("inv_step", {busy, step}, {1'b1, 2'd1});
    chk("inv_op_kept", alu_op, 1);
    sel(1);
    chk("inv_accept", step, 2);
    sel(1);
    sel(1);
    cyc();
    done();
    cyc();
    chk("inv_idle", busy, 0);

    // Selection timeout in GET_A
    s0 = starts;
    sb.push_back(er());
    op(0);
    repeat (15) cyc();
    chk("seltmo_pre", {busy, err}, {1'b1, 1'b0});
    cyc();
    chk("seltmo_err", {busy, err}, {1'b0, 1'b1});
    cyc();
    chk("seltmo_err_1cyc", err, 0);
    chk("seltmo_nostart", starts - s0, 0);

    // EXEC timeout, then late alu_done in IDLE
    sb.push_back(er());
    op(1);
    sel(1);
    sel(2);
    sel(3);
    repeat (7) cyc();
    chk("exectmo_pre", {busy, err}, {1'b1, 1'b0});
    cyc();
    chk("exectmo_err", {busy, err, wr_en}, {1'b0, 1'b1, 1'b0});
    done();
    cyc();
    chk("late_done", {busy, wr_en}, 0);

    // Cancel in GET_B
    op(0);
    sel(1);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    chk("cancel_b", {busy, err, step}, 0);

    // op_valid wins over reg_valid in IDLE; reg_valid alone ignored
    sel(2);
    chk("idle_sel_ign", busy, 0);
    op_valid  = 1'b1;
    op_code   = 2'd0;
    reg_valid = 1'b1;
    reg_sel   = 3'd2;
    cyc();
    op_valid  = 1'b0;
    reg_valid = 1'b0;
    chk("op_wins", step, 1);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;

    // Reset during EXEC
    op(2);
    sel(2);
    sel(3);
    sel(4);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_exec", outs(), 32'd0);
    rst = 1'b0;
    cyc();

    // cancel together with alu_done
    op(0);
    sel(1);
    sel(1);
    sel(1);
    cyc();
    cancel   = 1'b1;
    alu_done = 1'b1;
    cyc();
    cancel   = 1'b0;
    alu_done = 1'b0;
    chk("cancel_done", {busy, wr_en, err}, 0);
    repeat (3) cyc();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
